// File: rtl/btn_cond_pkg.sv
// Shared types and defaults for the push-button pulse conditioner.
// Holds the channel-state encoding, default timing constants and the L/R arbiter.
package btn_cond_pkg;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'b00,
        ST_PRESS_WAIT   = 2'b01,
        ST_PRESSED      = 2'b10,
        ST_RELEASE_WAIT = 2'b11
    } chan_state_e;

    localparam int unsigned DEBOUNCE_CYCLES_DEF = 16;
    localparam int unsigned HOLD_CYCLES_DEF     = 64;
    localparam int unsigned REPEAT_CYCLES_DEF   = 32;

    typedef struct packed {
        logic l;
        logic r;
        logic conflict;
    } pulse_out_t;

    // Left wins a same-cycle tie; the right pulse is dropped, not queued.
    function automatic pulse_out_t arbitrate(input logic pl, input logic pr);
        pulse_out_t o;
        o.l        = pl;
        o.r        = pr & ~pl;
        o.conflict = pl & pr;
        return o;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-flop synchroniser, debounce FSM + counter, press pulse.
// Ports: clk, reset (async, active-low), btn_raw in; pulse (1 cycle), held out.
// Optional AUTO_REPEAT_EN adds a hold counter producing repeat pulses.
module debounce_channel
    import btn_cond_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned HOLD_CYCLES     = HOLD_CYCLES_DEF,
    parameter int unsigned REPEAT_CYCLES   = REPEAT_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic pulse,
    output logic held
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 65535 ||
        HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_param
        $error("debounce_channel: illegal timing parameter");
    end

    logic        sync1_q, sync1_d;
    logic        sync2_q, sync2_d;
    chan_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic        press_evt;
    logic        rep_evt;
    logic        s;

    assign s = sync2_q;

    // State register (synchroniser, FSM state, debounce counter)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        sync1_d   = btn_raw;
        sync2_d   = sync1_q;
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_evt = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (s) begin
                    state_d = ST_PRESS_WAIT;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d = '0;
                end
            end
            ST_PRESS_WAIT: begin
                if (!s) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = ST_PRESSED;
                    cnt_d     = '0;
                    press_evt = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_PRESSED: begin
                if (!s) begin
                    state_d = ST_RELEASE_WAIT;
                    cnt_d   = CNT_ONE;
                end
            end
            ST_RELEASE_WAIT: begin
                if (s) begin
                    // Bounce back to pressed: no second pulse.
                    state_d = ST_PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

`ifdef AUTO_REPEAT_EN
    localparam int HMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int HW   = $clog2(HMAX + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [HW-1:0] REP_LAST  = HW'(REPEAT_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_ONE  = HW'(1);

    logic [HW-1:0] hold_q, hold_d;
    logic          rep_phase_q, rep_phase_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_q      <= '0;
            rep_phase_q <= 1'b0;
        end else begin
            hold_q      <= hold_d;
            rep_phase_q <= rep_phase_d;
        end
    end

    // Counts cycles spent in PRESSED with the level still high; the
    // first target is the hold delay, later targets the repeat period.
    always_comb begin
        hold_d      = hold_q;
        rep_phase_d = rep_phase_q;
        rep_evt     = 1'b0;
        if (state_q == ST_PRESSED && s) begin
            if (hold_q == (rep_phase_q ? REP_LAST : HOLD_LAST)) begin
                rep_evt     = 1'b1;
                hold_d      = '0;
                rep_phase_d = 1'b1;
            end else begin
                hold_d = hold_q + HOLD_ONE;
            end
        end else begin
            hold_d      = '0;
            rep_phase_d = 1'b0;
        end
    end
`else
    assign rep_evt = 1'b0;
`endif

    // Output logic
    always_comb begin
        pulse = press_evt | rep_evt;
        held  = (state_q == ST_PRESSED) || (state_q == ST_RELEASE_WAIT);
    end

endmodule

// File: rtl/button_pulse_cond.sv
// Top: two debounced button channels plus registered L/R arbitration.
// Ports: clk, reset (async, active-low), btn_l_raw, btn_r_raw in;
// L, R, conflict (registered pulses), l_held, r_held out. Macro: AUTO_REPEAT_EN.
module button_pulse_cond
    import btn_cond_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned HOLD_CYCLES     = HOLD_CYCLES_DEF,
    parameter int unsigned REPEAT_CYCLES   = REPEAT_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_l_raw,
    input  logic btn_r_raw,
    output logic L,
    output logic R,
    output logic conflict,
    output logic l_held,
    output logic r_held
);

    logic       pl, pr;
    pulse_out_t out_q, out_d;

    debounce_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .HOLD_CYCLES    (HOLD_CYCLES),
        .REPEAT_CYCLES  (REPEAT_CYCLES)
    ) u_left (
        .clk    (clk),
        .reset  (reset),
        .btn_raw(btn_l_raw),
        .pulse  (pl),
        .held   (l_held)
    );

    debounce_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .HOLD_CYCLES    (HOLD_CYCLES),
        .REPEAT_CYCLES  (REPEAT_CYCLES)
    ) u_right (
        .clk    (clk),
        .reset  (reset),
        .btn_raw(btn_r_raw),
        .pulse  (pr),
        .held   (r_held)
    );

    always_comb begin
        out_d = arbitrate(pl, pr);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign L        = out_q.l;
    assign R        = out_q.r;
    assign conflict = out_q.conflict;

endmodule

// File: doc/button_pulse_cond.md
Name: button_pulse_cond

Overview:
- Conditions two raw push-button inputs (left and right) into clean single-cycle pulses.
- Sits directly upstream of the speed-select FSM and drives its L and R inputs.
- Per button: 2-flop synchroniser, stable-level debounce counter, press-edge detect.
- Output arbitration guarantees L and R are never high in the same cycle.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive cycles the synchronised level must be stable before a press or release is accepted; legal range 2..65535.
- HOLD_CYCLES, 64: cycles a press must be held before the first auto-repeat pulse; used only with AUTO_REPEAT_EN.
- REPEAT_CYCLES, 32: period between auto-repeat pulses; used only with AUTO_REPEAT_EN.

Ports:
- clk  in  1  system clock; all flops on the rising edge.
- reset  in  1  asynchronous, active-low reset; 0 = reset.
- btn_l_raw  in  1  raw left button, asynchronous and bouncy, 1 = pressed.
- btn_r_raw  in  1  raw right button, asynchronous and bouncy, 1 = pressed.
- L  out  1  one-cycle left-press pulse to the FSM.
- R  out  1  one-cycle right-press pulse to the FSM.
- conflict  out  1  one-cycle flag: both channels pulsed in the same cycle.
- l_held  out  1  debounced left level (1 while in PRESSED or RELEASE_WAIT).
- r_held  out  1  debounced right level.

Behaviour:
- Reset (reset=0, asynchronous):
  - Synchroniser flops, counters and output registers clear to 0.
  - Channel state goes to IDLE.
  - L, R, conflict, l_held and r_held are all 0.
- Synchroniser: two flops per channel; s = second-flop output. Only s feeds the FSM.
- Channel FSM, counter width clog2(DEBOUNCE_CYCLES+1):
  - IDLE: s=1 -> PRESS_WAIT with cnt=1; otherwise stay, cnt=0.
  - PRESS_WAIT:
    - s=0 -> IDLE, cnt=0.
    - cnt==DEBOUNCE_CYCLES-1 with s=1 -> PRESSED, cnt=0, raise the channel pulse.
    - Otherwise cnt+1.
  - PRESSED: s=0 -> RELEASE_WAIT with cnt=1; otherwise stay.
  - RELEASE_WAIT:
    - s=1 -> PRESSED, cnt=0, no new pulse.
    - cnt==DEBOUNCE_CYCLES-1 with s=0 -> IDLE.
    - Otherwise cnt+1.
- Latency and pulse width:
  - Let k = the first edge at which flop 1 samples raw=1, with raw held thereafter.
  - The channel pulse is registered high for exactly the one cycle following edge k+1+DEBOUNCE_CYCLES.
  - Pulse width is always exactly 1 cycle, however long the button is held.
- Glitch rejection:
  - A bounce shorter than DEBOUNCE_CYCLES during PRESS_WAIT produces no pulse.
  - A bounce shorter than DEBOUNCE_CYCLES during RELEASE_WAIT produces no second pulse.
- Arbitration (registered together with the pulses):
  - Both channel pulses in the same cycle: L=1, R=0, conflict=1 for that cycle; the right press is dropped and not queued.
  - Otherwise L and R follow their channel pulses and conflict=0.
- Reset mid-operation: any in-progress count is discarded and no pulse is emitted.
- Button held through reset release: treated as a new press; one pulse after the full debounce latency.
- The counter never wraps: its maximum value is DEBOUNCE_CYCLES-1.

Optional Feature:
- Macro: AUTO_REPEAT_EN.
- Defined:
  - While in PRESSED, a hold counter runs.
  - First extra pulse when the hold counter reaches HOLD_CYCLES after entry to PRESSED.
  - Then one pulse every REPEAT_CYCLES while still PRESSED.
  - Leaving PRESSED, or entering RELEASE_WAIT, clears the hold counter.
  - Repeat pulses pass through the same arbitration.
- Undefined:
  - No hold counter is built.
  - Exactly one pulse per debounced press.
  - HOLD_CYCLES and REPEAT_CYCLES are ignored.

Decomposition:
- Package btn_cond_pkg:
  - Channel-state typedef: 2-bit IDLE=00, PRESS_WAIT=01, PRESSED=10, RELEASE_WAIT=11.
  - Default DEBOUNCE_CYCLES, HOLD_CYCLES and REPEAT_CYCLES constants.
- Sub-module debounce_channel, instantiated twice:
  - Contents: synchroniser, FSM, debounce counter, optional hold counter.
  - Outputs: pulse and held level.
- The top level holds the arbitration and output registers only.

Test Plan:
- Reset: hold reset=0 for 3 cycles with btn_l_raw=1 -> all outputs 0. Release reset -> L pulses once, 1 cycle, at edge k+1+DEBOUNCE_CYCLES.
- Clean left press, DEBOUNCE_CYCLES=4: btn_l_raw 0->1 held 50 cycles -> L=1 for one cycle after edge k+5. R=0 and conflict=0 throughout; l_held=1 from that cycle until 4 cycles after release.
- Bounce: btn_r_raw toggles 1,0,1,0 with 2-cycle widths, then stays 1 -> exactly one R pulse, timed from the final rising edge. Release with 2-cycle bounces -> no second pulse.
- Simultaneous: btn_l_raw and btn_r_raw rise on the same edge -> L=1, R=0, conflict=1 in the same single cycle. No R pulse follows.
- Mid-operation reset: reset=0 asserted while the left channel is in PRESS_WAIT at cnt=2 -> outputs go 0 immediately and no pulse is emitted. After reset release with raw still 1, the full debounce latency restarts.
- AUTO_REPEAT_EN, HOLD_CYCLES=8, REPEAT_CYCLES=4: hold left for 30 cycles after acceptance -> initial pulse, then pulses 8, 12, 16, 20, 24 and 28 cycles after entry to PRESSED. Release -> pulses stop.
